// File: rtl/dff_bank_arbiter_pkg.sv
// Shared definitions for the dff_bank_arbiter block: FSM encoding and a zero word.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package dff_bank_arbiter_pkg;

  // Controller states. Encoding 2'd3 is unused and decodes back to IDLE.
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_GRANT  = 2'd1,
    S_COMMIT = 2'd2
  } state_t;

  // Widest register the block supports; users slice the low WIDTH bits.
  localparam int MAX_WIDTH = 64;
  localparam logic [MAX_WIDTH-1:0] ZERO_WORD = '0;

endpackage

// File: rtl/dff_bank_arbiter_rr_pick.sv
// Round-robin priority picker: first set req bit at or above rr_ptr, wrapping to 0.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides when to act on the pick.
//
// Ports:
//   req    [NREQ-1:0]  request vector
//   rr_ptr [IDW-1:0]   index with highest priority this round
//   winner [IDW-1:0]   chosen index (0 when no request)
//   any                at least one request bit is set
module dff_bank_arbiter_rr_pick #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  rr_ptr,
  output logic [IDW-1:0]  winner,
  output logic            any
);

  logic           found;
  logic [IDW-1:0] idx;
  int             sum;

  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = '0;
    sum    = 0;
    any    = |req;
    for (int k = 0; k < NREQ; k++) begin
      // Wrap by explicit compare so non-power-of-2 NREQ rotates correctly.
      sum = int'(rr_ptr) + k;
      if (sum >= NREQ) sum = sum - NREQ;
      idx = IDW'(sum);
      if (!found && req[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dff_bank_arbiter.sv
// Round-robin arbiter and load sequencer for one shared WIDTH-bit register.
// Latency: req seen in IDLE at edge k -> gnt after k -> q loaded at k+1 -> ack in following cycle.
// Backpressure: requesters hold req until ack; a write occupies IDLE, GRANT, COMMIT (3 cycles min).
//
// Ports:
//   clk, rst_n                 rising-edge clock, async active-low reset
//   req   [NREQ-1:0]           level write requests, held until ack
//   data  [NREQ*WIDTH-1:0]     packed write data, requester i at [i*WIDTH +: WIDTH]
//   clear                      zero the register (serviced in IDLE, deferred otherwise)
//   gnt   [NREQ-1:0]           one-hot grant, high during GRANT
//   ack   [NREQ-1:0]           one-hot write-done pulse, high during COMMIT
//   q     [WIDTH-1:0]          shared register contents
//   owner [IDW-1:0]            last requester that committed a write
//   valid                      q holds data written since last reset/clear
//   busy                       high in GRANT and COMMIT
module dff_bank_arbiter
  import dff_bank_arbiter_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8,
  parameter int IDW   = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] data,
  input  logic                  clear,
  output logic [NREQ-1:0]       gnt,
  output logic [NREQ-1:0]       ack,
  output logic [WIDTH-1:0]      q,
  output logic [IDW-1:0]        owner,
  output logic                  valid,
  output logic                  busy
);

  state_t         state_q;
  state_t         state_d;
  logic [IDW-1:0] winner_q;
  logic [IDW-1:0] rr_ptr;
  logic           clr_pend;
  logic [IDW-1:0] pick_win;
  logic           pick_any;
  logic           clr_now;

  dff_bank_arbiter_rr_pick #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_rr_pick (
    .req    (req),
    .rr_ptr (rr_ptr),
    .winner (pick_win),
    .any    (pick_any)
  );

  // A clear, fresh or deferred, wins over arbitration in IDLE.
  assign clr_now = clear | clr_pend;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    gnt     = '0;
    ack     = '0;
    busy    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (!clr_now && pick_any) state_d = S_GRANT;
      end
      S_GRANT: begin
        gnt  = NREQ'(1) << winner_q;
        busy = 1'b1;
        // A requester that drops req here abandons the slot.
        state_d = req[winner_q] ? S_COMMIT : S_IDLE;
      end
      S_COMMIT: begin
        ack     = NREQ'(1) << winner_q;
        busy    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Winner latch, rotation pointer, deferred clear and the register bank itself.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      winner_q <= '0;
      rr_ptr   <= '0;
      clr_pend <= 1'b0;
      q        <= ZERO_WORD[WIDTH-1:0];
      owner    <= '0;
      valid    <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (clr_now) begin
            q        <= ZERO_WORD[WIDTH-1:0];
            valid    <= 1'b0;
            clr_pend <= 1'b0;
          end else if (pick_any) begin
            winner_q <= pick_win;
          end
        end
        S_GRANT: begin
          // Clear must not disturb an in-flight write; remember it for IDLE.
          if (clear) clr_pend <= 1'b1;
          if (req[winner_q]) begin
            q     <= data[int'(winner_q)*WIDTH +: WIDTH];
            owner <= winner_q;
            valid <= 1'b1;
          end
        end
        S_COMMIT: begin
          if (clear) clr_pend <= 1'b1;
          // Pointer advances only on a committed write, so an abort keeps priority.
          rr_ptr <= (winner_q == IDW'(NREQ-1)) ? '0 : winner_q + IDW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule
